// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first unsigned subtractor.
// One bit of each operand is combined with a registered borrow per cycle,
// using two cascaded half-subtraction steps. Operands arrive over a
// valid/ready input handshake and the result leaves over a valid/ready
// output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both 1. The producer must hold its valid high
// until that edge. in_ready_o is 1 only in IDLE and out_valid_o is 1 only
// in DONE, so the two handshakes can never fire in the same cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] diff_sr_q;
  logic             borrow_q;

  // One-bit subtraction slice: two cascaded half-subtractors.
  logic x_bit;
  logic y_bit;
  logic c_bit;
  logic hs1_diff;
  logic hs1_borrow;
  logic hs2_borrow;
  logic d_bit;
  logic b_next;
  logic last_bit;

  assign x_bit      = a_sr_q[0];
  assign y_bit      = b_sr_q[0];
  assign c_bit      = borrow_q;
  assign hs1_diff   = x_bit ^ y_bit;
  assign hs1_borrow = ~x_bit & y_bit;
  assign d_bit      = hs1_diff ^ c_bit;
  assign hs2_borrow = ~hs1_diff & c_bit;
  assign b_next     = hs1_borrow | hs2_borrow;
  assign last_bit   = (cnt_q == LAST_BIT);

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits in CALC, hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operand load, per-bit shift/borrow update, result capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      borrow_q  <= 1'b0;
      diff_o    <= '0;
      borrow_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_sr_q   <= a_i;
            b_sr_q   <= b_i;
            borrow_q <= bin_i;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          a_sr_q    <= a_sr_q >> 1;
          b_sr_q    <= b_sr_q >> 1;
          diff_sr_q <= {d_bit, diff_sr_q[WIDTH-1:1]};
          borrow_q  <= b_next;
          // Hold on the last bit so the counter never wraps.
          if (!last_bit) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            diff_o   <= {d_bit, diff_sr_q[WIDTH-1:1]};
            borrow_o <= b_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [WIDTH-1:0] got_diff_q[$];
  logic             got_borrow_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .bin_i      (bin),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .diff_o     (diff),
    .borrow_o   (borrow)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_diff_q.push_back(diff);
      got_borrow_q.push_back(borrow);
    end
  end

  // Driver: present an operand pair and hold it until accepted.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic binv, output int acc_cyc, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    acc_cyc = 0;
    @(negedge clk);
    a = av;
    b = bv;
    bin = binv;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  // Driver: count edges after accept until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    tests_run++;
    if (diff !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_diff got=%h exp=00", diff);
    end
    tests_run++;
    if (borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_borrow got=%b exp=0", borrow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One full transaction with out_ready high; checks latency and result.
  task automatic test_vector(input string name, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic binv,
                             input logic [WIDTH-1:0] exp_d, input logic exp_b);
    int t;
    int lat;
    bit ok;
    out_ready = 1'b1;
    send(av, bv, binv, t, ok);
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_accept got=%b exp=1", name, ok);
    end
    wait_out(lat);
    tests_run++;
    if (lat != WIDTH) begin
      tests_failed++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, lat, WIDTH);
    end
    tests_run++;
    if (diff !== exp_d) begin
      tests_failed++;
      $display("FAIL %s_diff got=%h exp=%h", name, diff, exp_d);
    end
    tests_run++;
    if (borrow !== exp_b) begin
      tests_failed++;
      $display("FAIL %s_borrow got=%b exp=%b", name, borrow, exp_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    test_vector("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
  endtask

  task automatic test_underflow();
    test_vector("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
  endtask

  task automatic test_borrow_in();
    test_vector("bin_a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    test_vector("bin_b", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_backpressure();
    int t;
    int lat;
    bit ok;
    int bad;
    out_ready = 1'b0;
    send(8'hC3, 8'h35, 1'b0, t, ok);
    wait_out(lat);
    tests_run++;
    if (lat != WIDTH || diff !== 8'h8E || borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_result lat=%0d diff=%h borrow=%b exp lat=%0d diff=8e borrow=0",
               lat, diff, borrow, WIDTH);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'h11 * i[7:0];
      b = 8'hF0 - 8'(i);
      bin = i[0];
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || diff !== 8'h8E || borrow !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bp_hold bad_cycles=%0d exp=0 (valid=%b diff=%h borrow=%b in_ready=%b)",
               bad, out_valid, diff, borrow, in_ready);
    end
    // Release: in_valid already up so the earliest possible accept is visible.
    a = 8'h22;
    b = 8'h11;
    bin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    tests_run++;
    if (diff !== 8'h8E || borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_keep_result diff=%h borrow=%b exp 8e/0", diff, borrow);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_next_accept in_ready=%b exp=0", in_ready);
    end
    wait_out(lat);
    tests_run++;
    if (lat != WIDTH || diff !== 8'h11 || borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_second lat=%0d diff=%h borrow=%b exp lat=%0d diff=11 borrow=0",
               lat, diff, borrow, WIDTH);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_calc();
    int t;
    bit ok;
    int pulses;
    out_ready = 1'b1;
    send(8'h5A, 8'h3C, 1'b0, t, ok);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs in_ready=%b out_valid=%b diff=%h borrow=%b exp 1/0/00/0",
               in_ready, out_valid, diff, borrow);
    end
    pulses = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL midrst_no_valid got=%0d exp=0", pulses);
    end
    test_vector("after_rst", 8'hFF, 8'h80, 1'b0, 8'h7F, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    bit ok1;
    bit ok2;
    int n;
    got_diff_q.delete();
    got_borrow_q.delete();
    out_ready = 1'b1;
    send(8'h05, 8'h03, 1'b0, t1, ok1);
    send(8'h03, 8'h05, 1'b0, t2, ok2);
    tests_run++;
    if (!(ok1 && ok2) || (t2 - t1) != WIDTH + 2) begin
      tests_failed++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, WIDTH + 2);
    end
    n = 0;
    while (got_diff_q.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (got_diff_q.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d exp=2", got_diff_q.size());
    end else begin
      tests_run++;
      if (got_diff_q[0] !== 8'h02 || got_borrow_q[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_first diff=%h borrow=%b exp 02/0", got_diff_q[0], got_borrow_q[0]);
      end
      tests_run++;
      if (got_diff_q[1] !== 8'hFE || got_borrow_q[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_second diff=%h borrow=%b exp fe/1", got_diff_q[1], got_borrow_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_in();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
